// File: rtl/button_pkg.sv
// Shared constants for the push-button conditioning path: debounce state codes and default timings.
package button_pkg;

    localparam logic [1:0] ST_IDLE         = 2'b00;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'b01;
    localparam logic [1:0] ST_PRESSED      = 2'b10;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'b11;

    localparam int CLK_HZ = 50_000_000;

    // 20 ms of stable level to accept a change, 1 s of holding for a long press.
    localparam int DEBOUNCE_CYCLES_DEF = CLK_HZ / 50;
    localparam int LONG_CYCLES_DEF     = CLK_HZ;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit, with a configurable reset value.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/button_conditioner.sv
// Turns one raw push-button pin into a debounced level, press/release/long-press pulses
// and a sticky request that stays up until a slower consumer acknowledges it.
module button_conditioner
    import button_pkg::*;
#(
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_btn_raw,
    input  logic       i_ack,
    output logic       o_level,
    output logic       o_press,
    output logic       o_release,
    output logic       o_hold,
    output logic       o_long_press,
    output logic [1:0] o_state_out
);

    localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int LCNT_W = $clog2(LONG_CYCLES);

    logic              w_pressedRaw;
    logic              w_sync;
    logic              w_dcntDone;
    logic              w_pressEvent;
    logic              w_releaseEvent;
    logic [1:0]        r_state;
    logic [DCNT_W-1:0] r_dcnt;
    logic [LCNT_W-1:0] r_lcnt;
    logic              r_longDone;
    logic              r_level;
    logic              r_press;
    logic              r_release;
    logic              r_hold;
    logic              r_longPress;

    // Normalise polarity before synchronising so 0 always means released.
    assign w_pressedRaw = i_btn_raw ^ ACTIVE_LOW;

    sync_2ff #(
        .RESET_VAL(1'b0)
    ) u_sync (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_d    (w_pressedRaw),
        .o_q    (w_sync)
    );

    assign w_dcntDone     = (r_dcnt == DCNT_W'(DEBOUNCE_CYCLES - 1));
    assign w_pressEvent   = (r_state == ST_PRESS_WAIT) && w_sync && w_dcntDone;
    assign w_releaseEvent = (r_state == ST_RELEASE_WAIT) && !w_sync && w_dcntDone;

    // Any sample that disagrees with the pending level drops back and restarts the count.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_dcnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_sync) begin
                        r_state <= ST_PRESS_WAIT;
                        r_dcnt  <= DCNT_W'(1);
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!w_sync) begin
                        r_state <= ST_IDLE;
                        r_dcnt  <= '0;
                    end else if (w_dcntDone) begin
                        r_state <= ST_PRESSED;
                        r_dcnt  <= '0;
                    end else begin
                        r_dcnt <= r_dcnt + 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (!w_sync) begin
                        r_state <= ST_RELEASE_WAIT;
                        r_dcnt  <= DCNT_W'(1);
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (w_sync) begin
                        r_state <= ST_PRESSED;
                        r_dcnt  <= '0;
                    end else if (w_dcntDone) begin
                        r_state <= ST_IDLE;
                        r_dcnt  <= '0;
                    end else begin
                        r_dcnt <= r_dcnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_dcnt  <= '0;
                end
            endcase
        end
    end

    // A fresh press outranks a simultaneous acknowledge so no request is ever lost.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_hold    <= 1'b0;
        end else begin
            r_press   <= w_pressEvent;
            r_release <= w_releaseEvent;
            if (w_pressEvent) begin
                r_level <= 1'b1;
            end else if (w_releaseEvent) begin
                r_level <= 1'b0;
            end
            if (w_pressEvent) begin
                r_hold <= 1'b1;
            end else if (i_ack && !r_press) begin
                r_hold <= 1'b0;
            end
        end
    end

    // The counter parks at its top value; the done flag keeps it to one pulse per press.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_lcnt      <= '0;
            r_longDone  <= 1'b0;
            r_longPress <= 1'b0;
        end else begin
            r_longPress <= 1'b0;
            if (w_pressEvent) begin
                r_lcnt     <= '0;
                r_longDone <= 1'b0;
            end else if ((r_state == ST_PRESSED) || (r_state == ST_RELEASE_WAIT)) begin
                if (r_lcnt == LCNT_W'(LONG_CYCLES - 1)) begin
                    if (!r_longDone) begin
                        r_longPress <= 1'b1;
                        r_longDone  <= 1'b1;
                    end
                end else begin
                    r_lcnt <= r_lcnt + 1'b1;
                end
            end
        end
    end

    assign o_level      = r_level;
    assign o_press      = r_press;
    assign o_release    = r_release;
    assign o_hold       = r_hold;
    assign o_long_press = r_longPress;
    assign o_state_out  = r_state;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a run-length model of the debouncer.
module tb_button_conditioner;

    localparam bit ACTIVE_LOW = 1'b1;
    localparam int DEB        = 4;
    localparam int LONG       = 16;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       btnRaw = 1'b1;
    logic       ack    = 1'b0;
    logic       level;
    logic       press;
    logic       releasePulse;
    logic       hold;
    logic       longPress;
    logic [1:0] stateOut;

    int checks   = 0;
    int failures = 0;

    button_conditioner #(
        .ACTIVE_LOW     (ACTIVE_LOW),
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LONG)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_btn_raw   (btnRaw),
        .i_ack       (ack),
        .o_level     (level),
        .o_press     (press),
        .o_release   (releasePulse),
        .o_hold      (hold),
        .o_long_press(longPress),
        .o_state_out (stateOut)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: the level flips once the synchronised input has disagreed with it
    // for DEB consecutive samples; the state code is {level, disagreement run pending}.
    bit mValid = 1'b0;
    bit mHist[$];
    bit mLevel, mPress, mRelease, mHold, mLong, mFired;
    int mRun, mAge;

    task automatic modelStep();
        bit p, s, levelPre, pressEv, relEv, longEv;
        if (reset) begin
            mHist.delete();
            mHist.push_back(1'b0);
            mHist.push_back(1'b0);
            mLevel = 0; mPress = 0; mRelease = 0; mHold = 0; mLong = 0; mFired = 0;
            mRun = 0; mAge = 0;
            mValid = 1'b1;
            return;
        end
        if (!mValid) return;
        p = btnRaw ^ ACTIVE_LOW;
        s = mHist.pop_front();
        mHist.push_back(p);
        levelPre = mLevel;
        pressEv = 0;
        relEv = 0;
        longEv = 0;
        if (s != mLevel) begin
            mRun++;
            if (mRun == DEB) begin
                mLevel = !mLevel;
                mRun = 0;
                if (mLevel) pressEv = 1;
                else relEv = 1;
            end
        end else begin
            mRun = 0;
        end
        if (levelPre && !mFired) begin
            mAge++;
            if (mAge == LONG) begin
                longEv = 1;
                mFired = 1;
            end
        end
        if (pressEv) begin
            mAge = 0;
            mFired = 0;
        end
        if (pressEv) mHold = 1;
        else if (ack && !mPress) mHold = 0;
        mPress = pressEv;
        mRelease = relEv;
        mLong = longEv;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            modelStep();
            #1;
            if (mValid) begin
                checkOutput("cmp.level", level, mLevel);
                checkOutput("cmp.press", press, mPress);
                checkOutput("cmp.release", releasePulse, mRelease);
                checkOutput("cmp.hold", hold, mHold);
                checkOutput("cmp.long", longPress, mLong);
                checkOutput("cmp.state", stateOut, {mLevel, (mRun != 0)});
            end
        end
    end

    task automatic applyStimulus(input logic btn, input logic a, input logic rst);
        @(negedge clk);
        btnRaw = btn;
        ack    = a;
        reset  = rst;
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 1'b1);
        stepEdge();
        stepEdge();
        applyStimulus(1'b1, 1'b0, 1'b0);
        stepEdge();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            stepEdge();
        end
    endtask

    initial begin
        int longCount;
        int longEdge;
        int relCount;
        logic btnSel;

        doReset();

        // Clean press with ack five cycles after the press pulse.
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(1'b0, (k == 11), 1'b0);
            stepEdge();
            checkOutput("t1.press", press, (k == 6));
            checkOutput("t1.level", level, (k >= 6));
            checkOutput("t1.state", stateOut, (k < 3) ? 2'b00 : (k < 6) ? 2'b01 : 2'b10);
            checkOutput("t4.hold", hold, (k >= 6) && (k < 11));
            checkOutput("t1.long", longPress, 1'b0);
        end

        // Release after the press above.
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            stepEdge();
            checkOutput("t3.release", releasePulse, (k == 6));
            checkOutput("t3.level", level, (k < 6));
            checkOutput("t3.state", stateOut, (k < 3) ? 2'b10 : (k < 6) ? 2'b11 : 2'b00);
            checkOutput("t3.long", longPress, 1'b0);
        end
        idle(3);

        // Bounce: low 3, high 1, then low stable.
        for (int k = 1; k <= 16; k++) begin
            applyStimulus((k == 4), 1'b0, 1'b0);
            stepEdge();
            checkOutput("t2.press", press, (k == 10));
            checkOutput("t2.level", level, (k >= 10));
        end
        idle(10);

        // Press coincident with ack: the new press keeps hold set.
        for (int k = 1; k <= 9; k++) begin
            applyStimulus(1'b0, (k >= 5) && (k <= 7), 1'b0);
            stepEdge();
            if (k == 5) checkOutput("t4.ackClears", hold, 1'b0);
            if (k == 6 || k == 7) checkOutput("t4.pressWins", hold, 1'b1);
        end
        idle(10);

        // Long hold: exactly one long_press, 16 edges after the press edge.
        longCount = 0;
        longEdge  = -1;
        for (int k = 1; k <= 40; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            stepEdge();
            if (longPress === 1'b1) begin
                longCount++;
                if (longEdge < 0) longEdge = k;
            end
        end
        checkOutput("t5.longCount", longCount, 1);
        checkOutput("t5.longEdge", longEdge, 22);
        idle(10);

        // Short hold of 10 cycles: no long_press.
        longCount = 0;
        for (int k = 1; k <= 40; k++) begin
            applyStimulus((k > 10), 1'b0, 1'b0);
            stepEdge();
            if (longPress === 1'b1) longCount++;
        end
        checkOutput("t5.shortNoLong", longCount, 0);

        // Reset while waiting on a held press, then the held button counts as a new press.
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            stepEdge();
        end
        checkOutput("t6.inPressWait", stateOut, 2'b01);
        applyStimulus(1'b0, 1'b0, 1'b1);
        stepEdge();
        checkOutput("t6.rstState", stateOut, 2'b00);
        checkOutput("t6.rstOutputs", {level, press, releasePulse, hold, longPress}, 5'b0);
        stepEdge();
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            stepEdge();
            checkOutput("t6.pressAfterRst", press, (k == 6));
        end

        // Reset while pressed produces no release pulse.
        applyStimulus(1'b0, 1'b0, 1'b1);
        stepEdge();
        checkOutput("t6.rstInPressed", {level, releasePulse}, 2'b00);
        relCount = 0;
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            stepEdge();
            if (releasePulse === 1'b1) relCount++;
        end
        checkOutput("t6.noRelease", relCount, 0);

        // Randomized segments mixing bounces, long holds, acks and rare resets.
        btnSel = 1'b1;
        for (int seg = 0; seg < 80; seg++) begin
            int len;
            btnSel = !btnSel;
            len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 40);
            for (int c = 0; c < len; c++) begin
                applyStimulus(btnSel, ($urandom_range(0, 7) == 0), ($urandom_range(0, 299) == 0));
                stepEdge();
            end
        end

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        failures++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
